// File: rtl/case_mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake on both sides.
// Optional feature: define MUL_SAT_EN to saturate (instead of wrap) narrowed results and drive sat_hit.
module case_mul_pipe_hs #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 14,
  parameter int din1_WIDTH  = 12,
  parameter int dout_WIDTH  = 26,
  parameter int SIGNED_MODE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [3:0]            occupancy,
  output logic                  sat_hit
);

  localparam int FW  = din0_WIDTH + din1_WIDTH;
  localparam bit SGN = (SIGNED_MODE != 0);

  if (NUM_STAGE < 1 || NUM_STAGE > 8 || ID < 0) begin : g_bad_cfg
    $error("case_mul_pipe_hs: NUM_STAGE must be in 1..8");
  end

  logic [FW-1:0]         w_a;
  logic [FW-1:0]         w_b;
  logic [FW-1:0]         w_p;
  logic [dout_WIDTH-1:0] w_res;
  logic                  w_fire_in;
  logic [NUM_STAGE-1:0]  w_take;
  logic [NUM_STAGE-1:0]  w_src_valid;
  logic [dout_WIDTH-1:0] w_src_data [NUM_STAGE];
  logic [NUM_STAGE-1:0]  w_nvalid;

  logic [NUM_STAGE-1:0]  r_valid;
  logic [dout_WIDTH-1:0] r_data [NUM_STAGE];
  logic [3:0]            r_occ;

  // Operands extended to full product width, so the low FW bits of an
  // unsigned multiply are the exact signed or unsigned product.
  assign w_a = {{din1_WIDTH{SGN & din0[din0_WIDTH-1]}}, din0};
  assign w_b = {{din0_WIDTH{SGN & din1[din1_WIDTH-1]}}, din1};
  assign w_p = w_a * w_b;

`ifdef MUL_SAT_EN
  localparam int XW = FW + dout_WIDTH;
  localparam logic [dout_WIDTH-1:0] ONE  = dout_WIDTH'(1);
  localparam logic [dout_WIDTH-1:0] SMIN = ONE << (dout_WIDTH - 1);
  localparam logic [dout_WIDTH-1:0] SMAX = ~SMIN;

  logic [XW-1:0] w_ext;
  logic          w_ovf;
  logic          r_sat;

  assign w_ext = {{dout_WIDTH{SGN & w_p[FW-1]}}, w_p};
  assign w_ovf = SGN ? !((&w_ext[XW-1:dout_WIDTH-1]) | ~(|w_ext[XW-1:dout_WIDTH-1]))
                     : (|w_ext[XW-1:dout_WIDTH]);
  assign w_res = !w_ovf ? w_ext[dout_WIDTH-1:0]
               : (!SGN ? {dout_WIDTH{1'b1}} : (w_ext[XW-1] ? SMIN : SMAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else if (w_fire_in && w_ovf) begin
      r_sat <= 1'b1;
    end
  end
  assign sat_hit = r_sat;
`else
  if (dout_WIDTH > FW) begin : g_widen
    assign w_res = {{(dout_WIDTH - FW){SGN & w_p[FW-1]}}, w_p};
  end else begin : g_wrap
    assign w_res = w_p[dout_WIDTH-1:0];
  end
  assign sat_hit = 1'b0;
`endif

  // Handshake: a pair moves on any cycle where valid and ready are both high
  // at the rising edge with ce=1; ready never waits on valid. A stage can take
  // new data when it or any later stage is empty, or the output is draining.
  always_comb begin
    logic v_acc;
    v_acc  = out_ready;
    w_take = '0;
    for (int k = NUM_STAGE - 1; k >= 0; k--) begin
      v_acc     = v_acc | !r_valid[k];
      w_take[k] = v_acc;
    end
  end

  assign in_ready  = ce & !reset & w_take[0];
  assign w_fire_in = in_valid & in_ready;

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_src
    if (k == 0) begin : g_first
      assign w_src_valid[k] = w_fire_in;
      assign w_src_data[k]  = w_res;
    end else begin : g_next
      assign w_src_valid[k] = r_valid[k-1];
      assign w_src_data[k]  = r_data[k-1];
    end
  end

  always_comb begin
    w_nvalid = r_valid;
    for (int k = 0; k < NUM_STAGE; k++) begin
      if (w_take[k]) w_nvalid[k] = w_src_valid[k];
    end
  end

  function automatic logic [3:0] f_popcnt(input logic [NUM_STAGE-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 0; k < NUM_STAGE; k++) c = c + 4'(v[k]);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_occ   <= 4'd0;
      for (int k = 0; k < NUM_STAGE; k++) r_data[k] <= '0;
    end else if (ce) begin
      r_valid <= w_nvalid;
      r_occ   <= f_popcnt(w_nvalid);
      for (int k = 0; k < NUM_STAGE; k++) begin
        if (w_take[k] && w_src_valid[k]) r_data[k] <= w_src_data[k];
      end
    end
  end

  assign out_valid = r_valid[NUM_STAGE-1];
  assign dout      = r_data[NUM_STAGE-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_case_mul_pipe_hs.sv
// Randomized scoreboard bench for case_mul_pipe_hs: four instances (default, unsigned
// widening, signed narrowing, signed widening) share one stimulus stream.
module tb_case_mul_pipe_hs;
  localparam int NI = 4;
  localparam int NS = 3;
`ifdef MUL_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam bit SGN [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam int DW  [NI] = '{26, 30, 8, 32};

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, out_ready;
  logic [13:0] din0;
  logic [11:0] din1;
  logic [25:0] d0;
  logic [29:0] d1;
  logic [7:0]  d2;
  logic [31:0] d3;
  logic        rdy [NI];
  logic        ov  [NI];
  logic        sat [NI];
  logic [3:0]  occ [NI];
  logic [31:0] dout_a [NI];

  logic [31:0] exp_q [NI][$];
  int          acc_q [$];
  bit          exp_sat [NI];
  logic [31:0] last_dout [NI];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          chk_lat = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  case_mul_pipe_hs #(.ID(1)) u_dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy[0]),
    .din0(din0), .din1(din1), .out_valid(ov[0]), .out_ready(out_ready), .dout(d0),
    .occupancy(occ[0]), .sat_hit(sat[0]));
  case_mul_pipe_hs #(.ID(2), .SIGNED_MODE(0), .dout_WIDTH(30)) u_uns (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy[1]),
    .din0(din0), .din1(din1), .out_valid(ov[1]), .out_ready(out_ready), .dout(d1),
    .occupancy(occ[1]), .sat_hit(sat[1]));
  case_mul_pipe_hs #(.ID(3), .dout_WIDTH(8)) u_nar (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy[2]),
    .din0(din0), .din1(din1), .out_valid(ov[2]), .out_ready(out_ready), .dout(d2),
    .occupancy(occ[2]), .sat_hit(sat[2]));
  case_mul_pipe_hs #(.ID(4), .dout_WIDTH(32)) u_wid (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy[3]),
    .din0(din0), .din1(din1), .out_valid(ov[3]), .out_ready(out_ready), .dout(d3),
    .occupancy(occ[3]), .sat_hit(sat[3]));

  assign dout_a[0] = {6'b0, d0};
  assign dout_a[1] = {2'b0, d1};
  assign dout_a[2] = {24'b0, d2};
  assign dout_a[3] = d3;

  // Reference: exact integer product, then clamp (saturating build) and keep dw bits.
  function automatic logic [31:0] model(input logic [13:0] a, input logic [11:0] b,
                                        input bit sgn, input int dw, output bit clamped);
    longint pa, pb, p, lo, hi;
    logic [63:0] m;
    pa = sgn ? longint'($signed(a)) : longint'(a);
    pb = sgn ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    clamped = 1'b0;
    if (SAT_EN) begin
      lo = sgn ? -(longint'(1) << (dw - 1)) : 64'sd0;
      hi = sgn ? (longint'(1) << (dw - 1)) - 1 : (longint'(1) << dw) - 1;
      if (p > hi) begin p = hi; clamped = 1'b1; end
      else if (p < lo) begin p = lo; clamped = 1'b1; end
    end
    m = 64'(p) & ((64'd1 << dw) - 64'd1);
    return m[31:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: check visible state against queued expectations, then
  // retire outputs that handshake and enqueue inputs that handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("occupancy[%0d]", i), 64'(occ[i]), 64'(exp_q[i].size()));
        chk($sformatf("in_ready[%0d]", i), 64'(rdy[i]),
            64'(ce && !reset && (exp_q[i].size() < NS || out_ready)));
        chk($sformatf("sat_hit[%0d]", i), 64'(sat[i]), 64'(exp_sat[i]));
        if (ov[i]) begin
          if (exp_q[i].size() == 0) chk($sformatf("unexpected_out[%0d]", i), 64'(ov[i]), 64'd0);
          else chk($sformatf("dout[%0d]", i), 64'(dout_a[i]), 64'(exp_q[i][0]));
        end
      end
      if (reset) begin
        for (int i = 0; i < NI; i++) begin
          exp_q[i].delete();
          exp_sat[i] = 1'b0;
        end
        acc_q.delete();
      end else if (ce) begin
        for (int i = 0; i < NI; i++) begin
          if (ov[i] && out_ready && exp_q[i].size() != 0) begin
            last_dout[i] = dout_a[i];
            void'(exp_q[i].pop_front());
            if (i == 0 && acc_q.size() != 0) begin
              int a;
              a = acc_q.pop_front();
              if (chk_lat) chk("latency", 64'(cyc - a), 64'(NS));
            end
          end
        end
        if (in_valid && rdy[0]) begin
          for (int i = 0; i < NI; i++) begin
            bit cl;
            exp_q[i].push_back(model(din0, din1, SGN[i], DW[i], cl));
            exp_sat[i] = exp_sat[i] | cl;
          end
          acc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b);
    int n;
    bit ok;
    in_valid = 1'b1;
    din0 = 14'(a);
    din1 = 12'(b);
    n = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = rdy[0];
      tick();
      n++;
    end
    if (!ok) chk("send_timeout", 64'(ok), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ce = 1'b1;
    while (exp_q[0].size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", 64'(exp_q[0].size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    bit acc;
    // Reset with a pending pair that must never appear
    reset = 1'b1; ce = 1'b1; in_valid = 1'b1; din0 = 14'd3; din1 = 12'd4; out_ready = 1'b1;
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("t1_out_valid", 64'(ov[i]), 64'd0);
      chk("t1_dout", 64'(dout_a[i]), 64'd0);
      chk("t1_occupancy", 64'(occ[i]), 64'd0);
    end
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (8) tick();

    // Narrowing 100*3 into 8 bits
    chk("t5_sat_before", 64'(sat[2]), 64'd0);
    send(100, 3);
    drain();
    chk("t5_dout", 64'(last_dout[2]), SAT_EN ? 64'd127 : 64'd44);
    chk("t5_sat_hit", 64'(sat[2]), 64'(SAT_EN));

    // Extremes
    send(-8192, -2048);
    drain();
    chk("t4_signed_min", 64'(last_dout[0]), 64'd16777216);
    chk("t4_signed_wide", 64'(last_dout[3]), 64'd16777216);
    send(16383, 4095);
    drain();
    chk("t4_unsigned_max", 64'(last_dout[1]), 64'd67088385);
    chk("t4_signed_m1", 64'(last_dout[0]), 64'd1);

    // Back-to-back stream with latency check
    chk_lat = 1'b1;
    send(-8, 5);
    send(7, -3);
    for (int k = 0; k < 8; k++) send(int'($urandom_range(0, 16383)), int'($urandom_range(0, 4095)));
    drain();
    chk_lat = 1'b0;

    // Backpressure: only NUM_STAGE pairs fit
    out_ready = 1'b0;
    in_valid = 1'b1;
    din0 = 14'($urandom); din1 = 12'($urandom);
    n_acc = 0;
    repeat (6) begin
      @(negedge clk);
      acc = rdy[0];
      if (acc) n_acc++;
      tick();
      if (acc) begin din0 = 14'($urandom); din1 = 12'($urandom); end
    end
    chk("t3_accepts", 64'(n_acc), 64'd3);
    @(negedge clk);
    chk("t3_in_ready", 64'(rdy[0]), 64'd0);
    chk("t3_occupancy", 64'(occ[0]), 64'd3);
    tick();
    drain();

    // Random traffic with ce and out_ready toggling
    repeat (400) begin
      ce = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1) != 0;
      din0 = 14'($urandom);
      din1 = 12'($urandom);
      tick();
    end
    drain();

    // ce freeze mid-stream
    for (int k = 0; k < 6; k++) send(int'($urandom_range(0, 16383)), int'($urandom_range(0, 4095)));
    in_valid = 1'b1;
    ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_ce_in_ready", 64'(rdy[0]), 64'd0);
      chk("t6_ce_out_valid", 64'(ov[0]), 64'd1);
      chk("t6_ce_occupancy", 64'(occ[0]), 64'd3);
      tick();
    end
    ce = 1'b1;
    drain();

    // Reset with a full pipeline
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(int'($urandom_range(0, 16383)), int'($urandom_range(0, 4095)));
    @(negedge clk);
    chk("t6_full", 64'(occ[0]), 64'd3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_rst_out_valid", 64'(ov[0]), 64'd0);
    chk("t6_rst_occupancy", 64'(occ[0]), 64'd0);
    repeat (10) begin
      tick();
      @(negedge clk);
      chk("t6_no_stale", 64'(ov[0]), 64'd0);
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
